// File: rtl/io_seq_pkg.sv
// Shared types and constants for the io_output_sequencer codebase.
// The optional IO_SEQ_TIMEOUT_EN watchdog is configured in io_output_sequencer.sv.
package io_seq_pkg;

  localparam int DEL_W_DEF = 21;
  localparam int DUR_W_DEF = 11;

  // HSTOP/ARST form the abort path: hard-stop cycle, then clear cycle.
  typedef enum logic [3:0] {
    IDLE, CLEAR, ARM, FIRE, WAIT, GAP, DONE, HSTOP, ARST
  } state_t;

  // Low bit of line idx inside a flattened bus of width-bit fields.
  function automatic int flat_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/io_output_sequencer_if.sv
// Host-side and line-side signal bundle for io_output_sequencer.
// The slave modport is the sequencer; master is whoever drives configuration and completes.
interface io_output_sequencer_if
  import io_seq_pkg::*;
#(
  parameter int N_LINES = 8,
  parameter int DEL_W   = DEL_W_DEF,
  parameter int DUR_W   = DUR_W_DEF,
  parameter int CNT_W   = 16,
  localparam int AW     = (N_LINES > 1) ? $clog2(N_LINES) : 1
);
  // No back-pressure anywhere: start, abort and cfg_we are single-cycle strobes
  // sampled on the clock edge; line_mark/line_go/line_rst/line_hardstop/done are
  // single-cycle strobes the receiver must take in the cycle they are high.
  logic                     cfg_we;
  logic [AW-1:0]            cfg_addr;
  logic [DEL_W-1:0]         cfg_delay;
  logic [DUR_W-1:0]         cfg_duration;
  logic [N_LINES-1:0]       cfg_enable;
  logic [CNT_W-1:0]         cfg_reps;
  logic [CNT_W-1:0]         cfg_gap;
  logic                     start;
  logic                     abort;
  logic [N_LINES-1:0]       line_complete;
  logic [N_LINES-1:0]       line_mark;
  logic [N_LINES-1:0]       line_go;
  logic                     line_rst;
  logic                     line_hardstop;
  logic [N_LINES*DEL_W-1:0] line_delay;
  logic [N_LINES*DUR_W-1:0] line_duration;
  logic                     busy;
  logic                     done;
  logic [CNT_W-1:0]         trig_count;
  logic                     err;
  state_t                   dbg_state;

  modport master (
    output cfg_we, cfg_addr, cfg_delay, cfg_duration, cfg_enable, cfg_reps, cfg_gap,
    output start, abort, line_complete,
    input  line_mark, line_go, line_rst, line_hardstop, line_delay, line_duration,
    input  busy, done, trig_count, err, dbg_state
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_delay, cfg_duration, cfg_enable, cfg_reps, cfg_gap,
    input  start, abort, line_complete,
    output line_mark, line_go, line_rst, line_hardstop, line_delay, line_duration,
    output busy, done, trig_count, err, dbg_state
  );

endinterface

// File: rtl/io_seq_table.sv
// Per-line delay/duration register file, presented as flattened buses.
// Writes land on the selected entry and appear on the outputs the next cycle.
module io_seq_table
  import io_seq_pkg::*;
#(
  parameter int N_LINES = 8,
  parameter int DEL_W   = DEL_W_DEF,
  parameter int DUR_W   = DUR_W_DEF,
  localparam int AW     = (N_LINES > 1) ? $clog2(N_LINES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [AW-1:0]            i_addr,
  input  logic [DEL_W-1:0]         i_delay,
  input  logic [DUR_W-1:0]         i_duration,
  output logic [N_LINES*DEL_W-1:0] o_delay,
  output logic [N_LINES*DUR_W-1:0] o_duration
);

  logic [DEL_W-1:0] r_delay    [N_LINES];
  logic [DUR_W-1:0] r_duration [N_LINES];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_LINES; i++) begin
        r_delay[i]    <= '0;
        r_duration[i] <= '0;
      end
    end else if (i_we) begin
      for (int i = 0; i < N_LINES; i++) begin
        if (i_addr == AW'(i)) begin
          r_delay[i]    <= i_delay;
          r_duration[i] <= i_duration;
        end
      end
    end
  end

  for (genvar g = 0; g < N_LINES; g++) begin : g_flat
    assign o_delay[flat_lsb(g, DEL_W) +: DEL_W]    = r_delay[g];
    assign o_duration[flat_lsb(g, DUR_W) +: DUR_W] = r_duration[g];
  end

endmodule

// File: rtl/io_output_sequencer.sv
// Sequences N output-line controllers through clear/arm/fire/wait/gap for a set number of triggers.
// Define IO_SEQ_TIMEOUT_EN to add a WAIT watchdog that flags err and takes the abort path.
module io_output_sequencer
  import io_seq_pkg::*;
#(
  parameter int N_LINES = 8,
  parameter int DEL_W   = DEL_W_DEF,
  parameter int DUR_W   = DUR_W_DEF,
  parameter int CNT_W   = 16,
  parameter int TO_W    = 24
) (
  input logic                  clk,
  input logic                  rst,
  io_output_sequencer_if.slave bus
);

  if (TO_W < 1) begin : g_to_w_chk
    $error("TO_W must be at least 1");
  end

  state_t             r_state, w_next;
  logic [N_LINES-1:0] r_enable;
  logic [CNT_W-1:0]   r_reps, r_gap, r_gap_cnt, r_trig;
  logic               r_err;
  logic [N_LINES-1:0] w_mark, w_go;
  logic               w_lrst, w_hstop, w_done, w_all_done, w_abortable, w_timeout;

  // Lines left out of the mask count as complete.
  assign w_all_done  = &(bus.line_complete | ~r_enable);
  assign w_abortable = r_state inside {CLEAR, ARM, FIRE, WAIT, GAP};

`ifdef IO_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] r_wdog;

  always_ff @(posedge clk) begin
    if (!rst || r_state != WAIT) r_wdog <= '0;
    else                         r_wdog <= r_wdog + 1'b1;
  end

  assign w_timeout = (r_state == WAIT) && (&r_wdog) && !w_all_done;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_mark  = '0;
    w_go    = '0;
    w_lrst  = 1'b0;
    w_hstop = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      IDLE:  if (bus.start) w_next = (bus.cfg_enable == '0) ? DONE : CLEAR;
      CLEAR: begin w_lrst = 1'b1; w_next = ARM; end
      ARM:   begin w_mark = r_enable; w_next = FIRE; end
      FIRE:  begin w_mark = r_enable; w_go = r_enable; w_next = WAIT; end
      WAIT: begin
        if (w_all_done)     w_next = GAP;
        else if (w_timeout) w_next = HSTOP;
      end
      GAP:   if (r_gap_cnt == '0) w_next = (r_trig < r_reps) ? CLEAR : DONE;
      // An empty mask reaches DONE without ever touching the lines.
      DONE:  begin w_done = 1'b1; w_lrst = |r_enable; w_next = IDLE; end
      HSTOP: begin w_hstop = 1'b1; w_next = ARST; end
      ARST:  begin w_lrst = 1'b1; w_next = IDLE; end
      default: w_next = IDLE;
    endcase
    if (bus.abort && w_abortable) w_next = HSTOP;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_enable  <= '0;
      r_reps    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_trig    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && bus.start) begin
        r_enable <= bus.cfg_enable;
        r_reps   <= (bus.cfg_reps == '0) ? CNT_W'(1) : bus.cfg_reps;
        r_gap    <= bus.cfg_gap;
        r_trig   <= '0;
        r_err    <= (bus.cfg_enable == '0);
      end else if ((bus.cfg_we && r_state != IDLE) || w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state == WAIT && w_next == GAP) begin
        r_trig    <= (&r_trig) ? r_trig : r_trig + 1'b1;
        r_gap_cnt <= r_gap;
      end else if (r_state == GAP && r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  io_seq_table #(
    .N_LINES (N_LINES),
    .DEL_W   (DEL_W),
    .DUR_W   (DUR_W)
  ) u_table (
    .clk        (clk),
    .rst        (rst),
    .i_we       (bus.cfg_we && r_state == IDLE),
    .i_addr     (bus.cfg_addr),
    .i_delay    (bus.cfg_delay),
    .i_duration (bus.cfg_duration),
    .o_delay    (bus.line_delay),
    .o_duration (bus.line_duration)
  );

  assign bus.line_mark     = w_mark;
  assign bus.line_go       = w_go;
  assign bus.line_rst      = w_lrst | ~rst;
  assign bus.line_hardstop = w_hstop;
  assign bus.done          = w_done;
  assign bus.busy          = (r_state != IDLE);
  assign bus.trig_count    = r_trig;
  assign bus.err           = r_err;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_io_output_sequencer.sv
// Directed bench for io_output_sequencer: go masks and done counts go through expected queues,
// everything else is checked in line at each step.
module tb_io_output_sequencer;
  import io_seq_pkg::*;

  localparam int N  = 8;
  localparam int DW = 21;
  localparam int UW = 11;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [N-1:0]  go_q[$];
  logic [CW-1:0] done_q[$];

  logic         resp_en = 1'b0;
  logic [N-1:0] resp_mask = '0;
  logic [N-1:0] resp_complete = '0;
  logic [N-1:0] man_complete = '0;
  int           resp_lat = 2;
  int           resp_cnt = -1;

  io_output_sequencer_if #(.N_LINES(N), .DEL_W(DW), .DUR_W(UW), .CNT_W(CW)) bus();

  assign bus.line_complete = resp_en ? resp_complete : man_complete;

  io_output_sequencer #(
    .N_LINES (N),
    .DEL_W   (DW),
    .DUR_W   (UW),
    .CNT_W   (CW),
    .TO_W    (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, observed time %0t", $time);
    $fatal(1, "global time limit reached");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input state_t s, input int budget, input string tag);
    int n = 0;
    while (bus.dbg_state !== s && n < budget) begin
      tick();
      n++;
    end
    check(tag, bus.dbg_state, s);
  endtask

  // Scoreboard side: every go strobe and done pulse must match the head of its queue.
  initial forever begin
    @(negedge clk);
    if (bus.line_go !== '0) begin
      if (go_q.size() == 0) check("go_unexpected", bus.line_go, '0);
      else begin
        check("go_mask", bus.line_go, go_q.pop_front());
        check("go_mark_match", bus.line_mark, bus.line_go);
      end
    end
    if (bus.done === 1'b1) begin
      if (done_q.size() == 0) check("done_unexpected", bus.done, 1'b0);
      else check("done_trig_count", bus.trig_count, done_q.pop_front());
    end
  end

  // Line model: complete rises resp_lat cycles after go, drops on line_rst or hard-stop.
  initial forever begin
    tick();
    if (resp_en) begin
      if (bus.line_rst || bus.line_hardstop) begin
        resp_complete = '0;
        resp_cnt = -1;
      end else if (bus.line_go != '0) resp_cnt = resp_lat;
      else if (resp_cnt > 0) resp_cnt--;
      else if (resp_cnt == 0) begin
        resp_complete = resp_mask;
        resp_cnt = -1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_write(input int addr, input logic [DW-1:0] d, input logic [UW-1:0] u);
    @(posedge clk); #1;
    bus.cfg_we       = 1'b1;
    bus.cfg_addr     = 3'(addr);
    bus.cfg_delay    = d;
    bus.cfg_duration = u;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic set_cfg(input logic [N-1:0] m, input logic [CW-1:0] reps, input logic [CW-1:0] gap);
    bus.cfg_enable = m;
    bus.cfg_reps   = reps;
    bus.cfg_gap    = gap;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_delay = '0; bus.cfg_duration = '0;
    bus.cfg_enable = '0; bus.cfg_reps = '0; bus.cfg_gap = '0;
    bus.start = 1'b0; bus.abort = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_state", bus.dbg_state, IDLE);
    check("rst_line_rst", bus.line_rst, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_err", bus.err, 1'b0);
    check("rst_trig", bus.trig_count, '0);
    check("rst_mark", bus.line_mark, '0);
    check("rst_delay_bus", bus.line_delay[63:0], '0);
    rst = 1'b1;
    tick();
    check("rel_line_rst", bus.line_rst, 1'b0);

    // Table writes, including full-scale values on the last line
    cfg_write(0, 21'd5, 11'd3);
    check("tbl_l0_delay", bus.line_delay[0 +: DW], 21'd5);
    cfg_write(1, 21'd0, 11'd2);
    cfg_write(7, 21'h1FFFFF, 11'h7FF);
    check("tbl_l0_dur", bus.line_duration[0 +: UW], 11'd3);
    check("tbl_l1_dur", bus.line_duration[UW +: UW], 11'd2);
    check("tbl_l7_delay", bus.line_delay[7*DW +: DW], 21'h1FFFFF);
    check("tbl_l7_dur", bus.line_duration[7*UW +: UW], 11'h7FF);

    // Single trigger, two lines, step by step
    set_cfg(8'h03, 16'd1, 16'd0);
    go_q.push_back(8'h03);
    done_q.push_back(16'd1);
    do_start();
    check("s1_clear_state", bus.dbg_state, CLEAR);
    check("s1_clear_rst", bus.line_rst, 1'b1);
    check("s1_busy", bus.busy, 1'b1);
    tick();
    check("s1_arm_state", bus.dbg_state, ARM);
    check("s1_arm_mark", bus.line_mark, 8'h03);
    check("s1_arm_go", bus.line_go, 8'h00);
    tick();
    check("s1_fire_go", bus.line_go, 8'h03);
    tick();
    check("s1_wait_state", bus.dbg_state, WAIT);
    check("s1_wait_strobes", {bus.line_go, bus.line_mark}, 16'h0000);
    tick();
    man_complete = 8'h01;
    tick();
    check("s1_wait_partial", bus.dbg_state, WAIT);
    man_complete = 8'h03;
    tick();
    check("s1_gap_state", bus.dbg_state, GAP);
    check("s1_gap_trig", bus.trig_count, 16'd1);
    tick();
    check("s1_done_pulse", bus.done, 1'b1);
    check("s1_done_rst", bus.line_rst, 1'b1);
    man_complete = 8'h00;
    tick();
    check("s1_idle", bus.dbg_state, IDLE);
    check("s1_idle_busy", bus.busy, 1'b0);
    check("s1_done_clear", bus.done, 1'b0);

    // Three triggers separated by a gap of 4
    set_cfg(8'h03, 16'd3, 16'd4);
    resp_mask = 8'hFF; resp_lat = 2; resp_en = 1'b1;
    repeat (3) go_q.push_back(8'h03);
    done_q.push_back(16'd3);
    do_start();
    for (int r = 0; r < 3; r++) begin
      wait_state(GAP, 50, "s2_reach_gap");
      t0 = cyc;
      if (r < 2) begin
        wait_state(CLEAR, 20, "s2_reach_clear");
        check("s2_gap_spacing", 64'(cyc - t0), 64'd5);
      end
    end
    wait_state(DONE, 20, "s2_reach_done");
    wait_state(IDLE, 5, "s2_reach_idle");
    check("s2_trig", bus.trig_count, 16'd3);
    check("s2_err", bus.err, 1'b0);

    // Only line 0 enabled; line 1 never completes
    set_cfg(8'h01, 16'd1, 16'd0);
    resp_mask = 8'h01;
    go_q.push_back(8'h01);
    done_q.push_back(16'd1);
    do_start();
    wait_state(IDLE, 40, "s3_finish");
    check("s3_trig", bus.trig_count, 16'd1);
    resp_en = 1'b0;

    // Abort in WAIT of the second trigger, racing a WAIT exit
    set_cfg(8'h03, 16'd2, 16'd0);
    man_complete = 8'h00;
    repeat (2) go_q.push_back(8'h03);
    do_start();
    wait_state(WAIT, 10, "s4_wait1");
    man_complete = 8'h03;
    wait_state(GAP, 5, "s4_gap1");
    check("s4_trig_gap1", bus.trig_count, 16'd1);
    man_complete = 8'h00;
    wait_state(WAIT, 10, "s4_wait2");
    tick();
    bus.abort = 1'b1;
    man_complete = 8'h03;
    tick();
    bus.abort = 1'b0;
    man_complete = 8'h00;
    check("s4_hstop_state", bus.dbg_state, HSTOP);
    check("s4_hstop", bus.line_hardstop, 1'b1);
    check("s4_hstop_no_rst", bus.line_rst, 1'b0);
    check("s4_hstop_trig", bus.trig_count, 16'd1);
    tick();
    check("s4_arst_hstop", bus.line_hardstop, 1'b0);
    check("s4_arst_rst", bus.line_rst, 1'b1);
    tick();
    check("s4_idle", bus.dbg_state, IDLE);
    check("s4_busy", bus.busy, 1'b0);
    check("s4_trig_kept", bus.trig_count, 16'd1);

    // Table write while busy, then reset in WAIT
    set_cfg(8'h01, 16'd1, 16'd0);
    go_q.push_back(8'h01);
    do_start();
    wait_state(WAIT, 10, "s5_wait");
    cfg_write(0, 21'd99, 11'd7);
    check("s5_tbl_kept_delay", bus.line_delay[0 +: DW], 21'd5);
    check("s5_tbl_kept_dur", bus.line_duration[0 +: UW], 11'd3);
    check("s5_err_set", bus.err, 1'b1);
    check("s5_still_wait", bus.dbg_state, WAIT);
    rst = 1'b0;
    tick();
    check("s5_rst_idle", bus.dbg_state, IDLE);
    check("s5_rst_busy", bus.busy, 1'b0);
    check("s5_rst_tbl", bus.line_delay[0 +: DW], 21'd0);
    check("s5_rst_tbl7", bus.line_duration[7*UW +: UW], 11'd0);
    check("s5_rst_line_rst", bus.line_rst, 1'b1);
    check("s5_rst_err", bus.err, 1'b0);
    rst = 1'b1;
    tick();
    check("s5_rel_line_rst", bus.line_rst, 1'b0);

    // Empty mask: err, done pulse, no line strobes
    set_cfg(8'h00, 16'd1, 16'd0);
    done_q.push_back(16'd0);
    do_start();
    check("s6_done_state", bus.dbg_state, DONE);
    check("s6_err", bus.err, 1'b1);
    check("s6_no_rst", bus.line_rst, 1'b0);
    check("s6_no_mark", bus.line_mark, 8'h00);
    tick();
    check("s6_idle", bus.dbg_state, IDLE);
    check("s6_err_sticky", bus.err, 1'b1);

    // reps=0 runs one trigger; start clears err
    set_cfg(8'h01, 16'd0, 16'd0);
    resp_mask = 8'h01; resp_en = 1'b1;
    go_q.push_back(8'h01);
    done_q.push_back(16'd1);
    do_start();
    check("s7_err_cleared", bus.err, 1'b0);
    wait_state(IDLE, 40, "s7_finish");
    check("s7_trig", bus.trig_count, 16'd1);
    resp_en = 1'b0;

    repeat (3) tick();
    check("sb_go_drained", 64'(go_q.size()), 64'd0);
    check("sb_done_drained", 64'(done_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
